led_seq_controller: RTL

//  Sequencer for the 3-bit pseudo-random LED counter datapath.
//  - Accepts a configuration (seed, step rate, burst length) over a valid/ready port.
//  - Starts and stops the sequence, and paces each step with a prescaler.
//  - Counts the steps of a burst and signals completion.
//  - Sits between board-level control (buttons/CSR) and the 3 LED outputs.

---
 rtl/led_seq_pkg.sv | 9 +
 rtl/led_seq_if.sv | 13 +
 rtl/led_seq_core.sv | 23 ++
 rtl/led_seq_controller.sv | 99 +++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, LFSR step function and constants for the LED sequencer
package led_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [2:0] SEED_SAFE = 3'b001;
    localparam logic [2:0] LFSR_TAP  = 3'b110;
    function automatic logic [2:0] lfsr3_next(input logic [2:0] q);
        return {q[1:0], ^(q & LFSR_TAP)};
    endfunction
endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: valid/ready configuration port carrying seed, step rate and burst length
interface led_seq_if #(
    parameter int DIV_W   = 8,
    parameter int STEPS_W = 8
) ();
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_seed;
    logic [DIV_W-1:0]   cfg_div;
    logic [STEPS_W-1:0] cfg_steps;
    modport master (output cfg_valid, cfg_seed, cfg_div, cfg_steps, input cfg_ready);
    modport slave  (input cfg_valid, cfg_seed, cfg_div, cfg_steps, output cfg_ready);
endinterface

// File: rtl/led_seq_core.sv
// led_seq_core: 3-bit maximal-length LFSR register with synchronous load and step
module led_seq_core
    import led_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       step,
    output logic [2:0] q
);
    logic [2:0] q_d, q_q;
    // load takes priority over step; otherwise hold
    always_comb begin
        q_d = load ? load_val : step ? lfsr3_next(q_q) : q_q;
    end
    // LFSR state register, cleared to 000 on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/led_seq_controller.sv
// led_seq_controller: config capture, start/stop FSM, step prescaler and burst counter around the LFSR
module led_seq_controller
    import led_seq_pkg::*;
#(
    parameter int         DIV_W    = 8,
    parameter int         STEPS_W  = 8,
    parameter logic [2:0] SEED_DEF = SEED_SAFE
) (
    input  logic          clk,
    input  logic          reset,
    led_seq_if.slave      cfg,
    input  logic          start,
    input  logic          stop,
    output logic [2:0]    led,
    output logic          busy,
    output logic          step_pulse,
    output logic          done,
    output logic          cfg_err
);
    state_t             state_d, state_q;
    logic [2:0]         seed_d, seed_q;
    logic [DIV_W-1:0]   div_d, div_q, divcnt_d, divcnt_q;
    logic [STEPS_W-1:0] steps_d, steps_q, remain_d, remain_q;
    logic               cfg_err_d, cfg_err_q, done_d, done_q;
    logic               ready, xfer, load_led, step_led, last_step;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state: stop always aborts to IDLE and beats a pending step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start && !stop) ? LOAD : IDLE;
            LOAD:    state_d = stop ? IDLE : RUN;
            RUN:     state_d = stop ? IDLE : (step_pulse && last_step) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // decoded outputs: handshake ready, busy flag and prescaler terminal count
    always_comb begin
        ready      = (state_q == IDLE);
        busy       = (state_q == LOAD) || (state_q == RUN);
        step_pulse = (state_q == RUN) && (divcnt_q == div_q);
    end
    assign cfg.cfg_ready = ready;

    // datapath next values: config capture, error flag, prescaler and burst counter
    always_comb begin
        xfer      = cfg.cfg_valid && ready;
        load_led  = (state_q == LOAD) && !stop;
        step_led  = step_pulse && !stop;
        last_step = (steps_q != '0) && (remain_q == STEPS_W'(1));
        seed_d    = xfer ? cfg.cfg_seed  : seed_q;
        div_d     = xfer ? cfg.cfg_div   : div_q;
        steps_d   = xfer ? cfg.cfg_steps : steps_q;
        cfg_err_d = xfer ? 1'b0 : (load_led && seed_q == 3'b000) ? 1'b1 : cfg_err_q;
        divcnt_d  = load_led ? '0 : (state_q != RUN) ? divcnt_q : step_pulse ? '0 : divcnt_q + DIV_W'(1);
        remain_d  = load_led ? steps_q : (step_led && steps_q != '0) ? remain_q - STEPS_W'(1) : remain_q;
        done_d    = (state_d == DONE);
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q    <= SEED_DEF;
            div_q     <= '0;
            steps_q   <= '0;
            divcnt_q  <= '0;
            remain_q  <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            seed_q    <= seed_d;
            div_q     <= div_d;
            steps_q   <= steps_d;
            divcnt_q  <= divcnt_d;
            remain_q  <= remain_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= done_d;
        end
    end

    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    led_seq_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_led),
        .load_val ((seed_q == 3'b000) ? SEED_DEF : seed_q),
        .step     (step_led),
        .q        (led)
    );
endmodule
